// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
//   Multi-cycle right shifter for the RV32I SRL/SRLI/SRA/SRAI datapath.
//   Shifts an n-bit operand right by shamt bits, one bit per clock. Logical
//   shifts fill with zeros. Arithmetic shifts fill with the sign bit that was
//   captured at start. The control unit stalls while busy is high.
//
// Build option
//   SHIFT_RIGHT_FAST4_EN : when defined, each SHIFT cycle moves 4 bits while at
//                          least 4 bits remain, then 1 bit per cycle. When the
//                          macro is undefined the block shifts 1 bit per cycle.
//                          The ports are the same in both builds.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request. It is sampled only in IDLE.
//   arith  in   1   1 = sign-fill, 0 = zero-fill. It is sampled with start.
//   A      in   n   operand. It is sampled with start.
//   shamt  in   sw  shift amount, 0..n-1. It is sampled with start.
//   B      out  n   result register. It shows intermediate values while
//                   shifting and holds the final value after done.
//   busy   out  1   high whenever the FSM is not in IDLE
//   done   out  1   one-cycle pulse. B is final while done is high.
//
// States
//   state   | meaning
//   S_IDLE  | waiting for start; B holds the last result
//   S_SHIFT | shifting B right; count holds the bits still to shift
//   S_DONE  | result final; done pulses for this single cycle
// -----------------------------------------------------------------------------
module shift_right_seq #(
  parameter int n  = 32,
  parameter int sw = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          arith,
  input  logic [n-1:0]  A,
  input  logic [sw-1:0] shamt,
  output logic [n-1:0]  B,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  b_q, b_d;
  logic [sw-1:0] count_q, count_d;
  logic          fill_q, fill_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // The next-state logic also computes busy and done for the next cycle.
  // This lets both outputs come directly from flops.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    count_d = count_q;
    fill_d  = fill_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = A;
          count_d = shamt;
          // The sign bit is captured here. It stays constant for the whole
          // operation, even though the top bits of B change while shifting.
          fill_d  = arith & A[n-1];
          busy_d  = 1'b1;
          if (shamt == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
`ifdef SHIFT_RIGHT_FAST4_EN
        if (count_q >= sw'(4)) begin
          b_d     = {{4{fill_q}}, b_q[n-1:4]};
          count_d = count_q - sw'(4);
          if (count_q == sw'(4)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          b_d     = {fill_q, b_q[n-1:1]};
          count_d = count_q - sw'(1);
          if (count_q == sw'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
`else
        b_d     = {fill_q, b_q[n-1:1]};
        count_d = count_q - sw'(1);
        if (count_q == sw'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign B    = b_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          arith = 1'b0;
  logic [N-1:0]  A = '0;
  logic [SW-1:0] shamt = '0;
  logic [N-1:0]  B;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  shift_right_seq #(.n(N), .sw(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .arith(arith),
    .A(A), .shamt(shamt), .B(B), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: the result of the shift, computed directly.
  function automatic logic [N-1:0] ref_result(logic [N-1:0] a, int sh, logic ar);
    if (ar) return N'($signed(a) >>> sh);
    else    return a >> sh;
  endfunction

  // Number of rising edges from the start edge (counted as 1) to the first
  // edge after which done is high.
  function automatic int ref_edges(int sh);
`ifdef SHIFT_RIGHT_FAST4_EN
    return sh / 4 + sh % 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < LIMIT && busy; i++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  // Runs one operation. If inj > 0, a second request with junk operands is
  // driven for one cycle after edge inj. The DUT must ignore it.
  task automatic run_op(input logic [N-1:0] a, input int sh, input logic ar,
                        input int inj,
                        output logic [N-1:0] res, output int edges,
                        output int busy_cnt, output bit to);
    wait_idle();
    @(negedge clk);
    A = a; shamt = SW'(sh); arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1; busy_cnt = 0; to = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (inj > 0 && edges == inj) begin
        A = 32'h0000_0001; shamt = SW'(1); arith = ~ar; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    if (!done) to = 1'b1;
    res = B;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] a, input int sh,
                          input logic ar, input int inj, input logic [N-1:0] exp_res);
    logic [N-1:0] res;
    int edges, bc;
    bit to;
    run_op(a, sh, ar, inj, res, edges, bc, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d edges", name, LIMIT);
    end
    total++;
    if (res !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h required %h", name, res, exp_res);
    end
    total++;
    if (edges != ref_edges(sh)) begin
      bad++;
      $display("FAIL %s latency: got %0d required %0d", name, edges, ref_edges(sh));
    end
    total++;
    if (bc != ref_edges(sh)) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, ref_edges(sh));
    end
    // One cycle later: the pulse is over, the FSM is idle, and B holds its value.
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || B !== exp_res) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b B=%h required 0 0 %h",
               name, done, busy, B, exp_res);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (B !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: B=%h busy=%b done=%b required 0 0 0", B, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (B !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: B=%h busy=%b done=%b required 0 0 0", B, busy, done);
    end
  endtask

  task automatic test_directed();
    check_op("log4",     32'h8000_0000, 4,  1'b0, 0, 32'h0800_0000);
    check_op("ari4",     32'h8000_0000, 4,  1'b1, 0, 32'hF800_0000);
    check_op("zero",     32'h1234_ABCD, 0,  1'b0, 0, 32'h1234_ABCD);
    check_op("ari31",    32'h8000_0000, 31, 1'b1, 0, 32'hFFFF_FFFF);
    check_op("log31",    32'h8000_0000, 31, 1'b0, 0, 32'h0000_0001);
    check_op("ari_pos",  32'h7000_0000, 5,  1'b1, 0, 32'h0380_0000);
  endtask

  task automatic test_ignore_busy();
    check_op("ignore",   32'hF0F0_F0F0, 8,  1'b0, 2, 32'h00F0_F0F0);
  endtask

  task automatic test_mid_reset();
    wait_idle();
    @(negedge clk);
    A = 32'hDEAD_BEEF; shamt = SW'(10); arith = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (B !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: B=%h busy=%b done=%b required 0 0 0", B, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_hold: done=%b busy=%b required 0 0", done, busy);
      end
    end
    @(negedge clk); rst = 1'b0;
    check_op("post_rst", 32'hDEAD_BEEF, 10, 1'b1, 0, ref_result(32'hDEAD_BEEF, 10, 1'b1));
  endtask

  // With start held high, a new request is accepted in the IDLE cycle after
  // each done. So done pulses repeat every latency+1 edges.
  task automatic test_back_to_back();
    int gap;
    wait_idle();
    @(negedge clk);
    A = 32'h8765_4321; shamt = SW'(3); arith = 1'b1; start = 1'b1;
    for (int i = 0; i < LIMIT && !done; i++) begin @(posedge clk); #1; end
    total++;
    if (B !== ref_result(32'h8765_4321, 3, 1'b1)) begin
      bad++;
      $display("FAIL b2b_first: got %h required %h", B, ref_result(32'h8765_4321, 3, 1'b1));
    end
    A = 32'h0F00_0000; shamt = SW'(6); arith = 1'b0;
    gap = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk); #1; gap++;
      if (done) break;
    end
    start = 1'b0;
    total++;
    if (gap != ref_edges(6) + 1) begin
      bad++;
      $display("FAIL b2b_gap: got %0d required %0d", gap, ref_edges(6) + 1);
    end
    total++;
    if (B !== ref_result(32'h0F00_0000, 6, 1'b0)) begin
      bad++;
      $display("FAIL b2b_second: got %h required %h", B, ref_result(32'h0F00_0000, 6, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    int sh;
    logic ar;
    for (int k = 0; k < 30; k++) begin
      a  = $urandom;
      sh = int'($urandom_range(0, N - 1));
      ar = 1'($urandom_range(0, 1));
      check_op("rand", a, sh, ar, (k % 3 == 0) ? 1 : 0, ref_result(a, sh, ar));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
